// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: read owner tags and the
// width of the data-streak counter used by the MEM_ARB_FAIR_EN build.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Fixed-depth delay line for read owner tags; the tag leaving the last
// stage marks the cycle its read data is present on the memory bus.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage;

  // Reset drops every in-flight tag so no stale read is ever returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with in-order read return.
// Define MEM_ARB_FAIR_EN to bound fetch starvation with a data-streak counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rdvalid,
  output logic [15:0] o_if_rddata,
  input  logic        i_d_req,
  input  logic        i_d_wr,
  input  logic [15:0] i_d_addr,
  input  logic [15:0] i_d_wrdata,
  output logic        o_d_gnt,
  output logic        o_d_rdvalid,
  output logic [15:0] o_d_rddata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic [15:0] i_mem_rddata
);

  // Handshake: a requester holds req and its payload stable until it sees
  // its gnt; gnt is combinational and the transfer happens in that cycle.
  logic if_gnt;
  logic d_gnt;
  tag_t tag_in;
  tag_t tag_out;

`ifdef MEM_ARB_FAIR_EN
  logic [STREAK_W-1:0] streak;
  logic                fetch_turn;

  assign fetch_turn = (streak == STREAK_W'(MAX_DATA_STREAK));

  // Counts data grants taken while fetch is waiting; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (!i_if_req || if_gnt) begin
      streak <= '0;
    end else if (d_gnt && !fetch_turn) begin
      streak <= streak + 1'b1;
    end
  end

  assign d_gnt = !reset && i_d_req && !(i_if_req && fetch_turn);
`else
  assign d_gnt = !reset && i_d_req;
`endif

  assign if_gnt = !reset && i_if_req && !d_gnt;

  assign o_if_gnt     = if_gnt;
  assign o_d_gnt      = d_gnt;
  assign o_mem_addr   = d_gnt ? i_d_addr : i_if_addr;
  assign o_mem_rd     = if_gnt || (d_gnt && !i_d_wr);
  assign o_mem_wr     = d_gnt && i_d_wr;
  assign o_mem_wrdata = i_d_wrdata;

  assign tag_in.valid = o_mem_rd;
  assign tag_in.owner = if_gnt ? OWNER_IF : OWNER_D;

  mem_arb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign o_if_rdvalid = tag_out.valid && (tag_out.owner == OWNER_IF);
  assign o_d_rdvalid  = tag_out.valid && (tag_out.owner == OWNER_D);
  assign o_if_rddata  = i_mem_rddata;
  assign o_d_rddata   = i_mem_rddata;

endmodule
